// File: rtl/ddr2_host_port.sv
// ddr2_host_port: client front end for ddr2_controller; stages writes, issues commands, tracks reads.
// Optional macro DDR2_HP_TIMEOUT_EN adds a read-return watchdog driving the sticky err flag.
module ddr2_host_port #(
    parameter int MAX_OUTST = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [24:0] req_addr,
    input  logic [1:0]  req_sz,
    input  logic [2:0]  req_op,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic [2:0]  ctl_cmd,
    output logic [24:0] ctl_addr,
    output logic [1:0]  ctl_sz,
    output logic [2:0]  ctl_op,
    output logic [15:0] ctl_din,
    input  logic        ctl_notfull,
    input  logic        ctl_ready,
    input  logic        ctl_validout,
    input  logic [15:0] ctl_dout,
    input  logic [24:0] ctl_raddr,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [24:0] rsp_addr,
    output logic [6:0]  outst_cnt,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, STREAM} state_t;

    localparam logic [2:0] C_SCR = 3'b001;
    localparam logic [2:0] C_SCW = 3'b010;
    localparam logic [2:0] C_BLR = 3'b011;
    localparam logic [2:0] C_BLW = 3'b100;
    localparam logic [2:0] C_ATR = 3'b101;
    localparam logic [2:0] C_ATW = 3'b110;
    localparam logic [7:0] MAX_W = 8'(MAX_OUTST);

    state_t      state_q, state_d;
    logic [2:0]  cmd_q;
    logic [24:0] addr_q;
    logic [1:0]  sz_q;
    logic [2:0]  op_q;
    logic        rd_q;
    logic [5:0]  words_q;
    logic [4:0]  idx_q;
    logic [15:0] buf_q [32];
    logic [6:0]  outst_q;

    logic        acc, req_fire, wr_fire, last;
    logic        req_rd, req_blk, tmo_hit;
    logic [5:0]  req_words, add_w;
    logic [7:0]  need, sum;

    assign acc       = ctl_notfull & ctl_ready;
    assign req_words = {1'b0, req_sz, 3'b000} + 6'd8;
    assign need      = {1'b0, outst_q} + (req_blk ? {2'b0, req_words} : 8'd1);
    assign req_ready = (state_q == IDLE) & ctl_ready & (~req_rd | (need <= MAX_W));
    assign wr_ready  = (state_q == COLLECT);
    assign req_fire  = req_valid & req_ready;
    assign wr_fire   = wr_valid & wr_ready;
    assign last      = ({1'b0, idx_q} == words_q - 6'd1);
    assign add_w     = (state_q == ISSUE && acc && rd_q) ? words_q : 6'd0;
    assign sum       = {1'b0, outst_q} + {2'b0, add_w};
    assign outst_cnt = outst_q;
    assign busy      = (state_q != IDLE) | (outst_q != 7'd0);

    // classify the incoming request command
    always_comb begin
        req_rd  = 1'b0;
        req_blk = 1'b0;
        unique case (req_cmd)
            C_SCR, C_ATR: req_rd = 1'b1;
            C_BLR: begin
                req_rd  = 1'b1;
                req_blk = 1'b1;
            end
            C_BLW: req_blk = 1'b1;
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_fire) begin
                unique case (req_cmd)
                    C_SCR, C_BLR: state_d = ISSUE;
                    C_SCW, C_BLW, C_ATR, C_ATW: state_d = COLLECT;
                    default: state_d = IDLE;
                endcase
            end
            COLLECT: if (wr_fire && last) state_d = ISSUE;
            ISSUE: if (acc) state_d = (cmd_q == C_BLW) ? STREAM : IDLE;
            STREAM: if (acc && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // staging buffer; contents are meaningless once idx is reset
    always_ff @(posedge clk) begin
        if (wr_fire) buf_q[idx_q] <= wr_data;
    end

    // request latch, staging index and registered controller drive
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q <= '0; addr_q <= '0; sz_q <= '0; op_q <= '0;
            rd_q <= 1'b0; words_q <= '0; idx_q <= '0;
            ctl_cmd <= '0; ctl_addr <= '0; ctl_sz <= '0;
            ctl_op <= '0; ctl_din <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (req_fire) begin
                    cmd_q   <= req_cmd;
                    addr_q  <= req_addr;
                    sz_q    <= req_sz;
                    op_q    <= req_op;
                    rd_q    <= req_rd;
                    words_q <= req_blk ? req_words : 6'd1;
                    idx_q   <= '0;
                    if (state_d == ISSUE) begin
                        ctl_cmd  <= req_cmd;
                        ctl_addr <= req_addr;
                        ctl_sz   <= req_sz;
                        ctl_op   <= req_op;
                        ctl_din  <= buf_q[0];
                    end
                end
                COLLECT: if (wr_fire) begin
                    if (last) begin
                        idx_q    <= '0;
                        ctl_cmd  <= cmd_q;
                        ctl_addr <= addr_q;
                        ctl_sz   <= sz_q;
                        ctl_op   <= op_q;
                        ctl_din  <= (idx_q == 5'd0) ? wr_data : buf_q[0];
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                ISSUE: if (acc) begin
                    ctl_cmd <= '0;
                    if (cmd_q == C_BLW) begin
                        idx_q   <= 5'd1;
                        ctl_din <= buf_q[1];
                    end
                end
                STREAM: if (acc) begin
                    if (last) begin
                        idx_q <= '0;
                    end else begin
                        idx_q   <= idx_q + 5'd1;
                        ctl_din <= buf_q[idx_q + 5'd1];
                    end
                end
                default: ;
            endcase
        end
    end

    // outstanding read words: issue adds, each return subtracts, floor at zero
    always_ff @(posedge clk) begin
        if (reset)                        outst_q <= '0;
        else if (tmo_hit)                 outst_q <= '0;
        else if (ctl_validout && sum != 0) outst_q <= 7'(sum - 8'd1);
        else                              outst_q <= sum[6:0];
    end

    // register returned words toward the client
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= ctl_validout;
            if (ctl_validout) begin
                rsp_data <= ctl_dout;
                rsp_addr <= ctl_raddr;
            end
        end
    end

`ifdef DDR2_HP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_hit = ~ctl_validout & (outst_q != 7'd0)
                   & (tmo_q == TW'(TIMEOUT - 1));

    // watchdog on read returns; err stays set until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err   <= 1'b0;
        end else if (ctl_validout || outst_q == 7'd0) begin
            tmo_q <= '0;
        end else if (tmo_hit) begin
            tmo_q <= '0;
            err   <= 1'b1;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0 & (TIMEOUT < 0);
`endif

endmodule
